mult_accumulate_stage: RTL and testbench
========================================

// Module: mult_accumulate_stage
// PURPOSE
//   Downstream consumer of the 32x32 multiplier's 64-bit product P. Tracks operands issued to the
//   multiplier through a valid/last delay line matching multiplier latency, accumulates the products
//   of one block (terminated by in_last) and presents the sum on a valid/ready output.
//   It is the dot-product / MAC stage after the multiplier in the datapath.
// PARAMETERS
//   MUL_LATENCY  1   clock cycles from operands at the multiplier inputs to the matching P; range 0..8
//   ACC_W        72  accumulator width in bits; must be >= 64
//   CNT_W        8   product-count width; the count saturates at 2**CNT_W-1
// PORTS
//   clk        in   1      clock; all state changes on the rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands presented to the multiplier this cycle
//   in_last    in   1      qualifies in_valid; this is the final operand pair of the block
//   in_ready   out  1      stage accepts an operand pair; transfer = in_valid & in_ready
//   mul_p      in   64     product from the multiplier; sampled only when the delayed valid is high
//   out_valid  out  1      acc_out, out_count and out_ovf are valid
//   out_ready  in   1      downstream accepts the result; transfer = out_valid & out_ready
//   acc_out    out  ACC_W  unsigned sum of the block's products, modulo 2**ACC_W
//   out_count  out  CNT_W  number of products in the block; saturating
//   out_ovf    out  1      sticky flag: a carry left ACC_W during the block
// BEHAVIOUR
//   Reset: state=ACCUM, acc=0, count=0, ovf=0, delay line cleared, out_valid=0, acc_out=0, out_count=0, out_ovf=0.
//     in_ready goes to 1 in the first cycle after reset.
//   Delay line: MUL_LATENCY stages of {v,last}; stage 0 input = {in_valid&in_ready, in_last}.
//     With MUL_LATENCY=0, mul_p pairs with the current transfer.
//   Accumulate: when the tail v=1, acc <= acc + zero-extended mul_p (ACC_W+1-bit add).
//     The carry-out sets ovf; count <= count+1, saturating.
//   FSM:
//     ACCUM: in_ready=1. A transfer with in_last=1 -> DRAIN; in_ready=0 from the next cycle.
//     DRAIN: in_ready=0. The delay-line tail with v=1 and last=1 accumulates. The next cycle loads
//       acc_out/out_count/out_ovf with the final values, sets out_valid=1 and moves to HOLD.
//     HOLD: in_ready=0; outputs stay stable until out_ready. On the handshake: out_valid=0; acc,
//       count and ovf clear; -> ACCUM.
//   Latency: the last product reaches out_valid MUL_LATENCY+1 cycles after the last transfer
//     (after 1 cycle when MUL_LATENCY=0).
//   Single-element block (first transfer has in_last=1): result = that one product, count=1.
//   Back-to-back blocks: the next block's first transfer is accepted in the cycle after the output handshake.
//   out_ready is ignored while out_valid=0. in_last is ignored when in_valid=0.
//   Products that arrive between non-last transfers accumulate in order, no bubbles needed.
//   Sum wraps modulo 2**ACC_W when ovf=1.
//   Reset mid-operation: in-flight products are discarded, any pending result is dropped, and the
//     stage returns to the reset state.
// STRUCTURE
//   Package mac_pkg: ACC_W and CNT_W defaults; state enum typedef {ACCUM, DRAIN, HOLD}.
//   One sub-module: mac_valid_delay (parameterised {v,last} shift register, depth MUL_LATENCY,
//     synchronous clear on rst).
//   The accumulator, counter and FSM live in the top-level module.
// TESTING
//   Model MUL_LATENCY with a registered A*B stub; run at MUL_LATENCY=1 and at 3.
//   1. Block of 4 pairs (2*3, 4*5, 6*7, 8*9), out_ready=1 -> acc_out=140, out_count=4, out_ovf=0.
//      out_valid is asserted MUL_LATENCY+1 cycles after the last transfer.
//   2. Single pair 0xFFFFFFFF*0xFFFFFFFF with in_last=1 -> acc_out=0xFFFFFFFE00000001, out_count=1.
//   3. ACC_W=64, two products of 0xFFFFFFFE00000001 -> acc_out=0xFFFFFFFC00000002 and out_ovf=1.
//   4. out_ready held 0 for 10 cycles in HOLD -> in_ready=0 and the outputs stay stable.
//      The cycle after out_ready=1, in_ready=1, and a new block of 1*1 gives 1.
//   5. rst pulsed during DRAIN -> out_valid never asserts for that block.
//      A following block of 3*3 gives 9 with out_count=1.
//   6. CNT_W=2, block of 5 pairs of 1*1 -> acc_out=5, out_count=3 (saturated).

Source files
------------

// File: rtl/mac_pkg.sv
// Shared defaults and state encoding for the multiply-accumulate stage.
package mac_pkg;
  localparam int ACC_W_DEF = 72;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} mac_state_t;
endpackage

// File: rtl/mac_valid_delay.sv
// {valid,last} shift register that mirrors the multiplier latency so each
// product arrives together with the control bits of its operand pair.
module mac_valid_delay
  import mac_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic v,
  input  logic last,
  output logic tail_v,
  output logic tail_last
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign tail_v    = v;
      assign tail_last = last;
    end else begin : g_shift
      logic [DEPTH-1:0] vld_p;
      logic [DEPTH-1:0] last_p;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p  <= '0;
          last_p <= '0;
        end else begin
          vld_p[0]  <= v;
          last_p[0] <= last;
          for (int i = 1; i < DEPTH; i++) begin
            vld_p[i]  <= vld_p[i-1];
            last_p[i] <= last_p[i-1];
          end
        end
      end

      assign tail_v    = vld_p[DEPTH-1];
      assign tail_last = last_p[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mult_accumulate_stage.sv
// Accumulates one block of multiplier products and hands the sum, product
// count and overflow flag to a valid/ready consumer.
module mult_accumulate_stage
  import mac_pkg::*;
#(
  parameter int MUL_LATENCY = 1,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [63:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  mac_state_t       state;
  logic             ready_q;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             done_p1;
  logic             tail_v;
  logic             tail_last;
  logic [ACC_W:0]   sum_wide;

  assign in_ready = ready_q;

  // Stage 0 -> multiplier-latency tail
  mac_valid_delay #(.DEPTH(MUL_LATENCY)) u_delay (
    .clk       (clk),
    .rst       (rst),
    .v         (in_valid & ready_q),
    .last      (in_last),
    .tail_v    (tail_v),
    .tail_last (tail_last)
  );

  assign sum_wide = {1'b0, acc} + {{(ACC_W + 1 - 64){1'b0}}, mul_p};

  // Tail -> accumulator; done_p1 marks that the block's last product is in acc
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      ready_q   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      done_p1   <= 1'b0;
      out_valid <= 1'b0;
      acc_out   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (tail_v) begin
        acc <= sum_wide[ACC_W-1:0];
        ovf <= ovf | sum_wide[ACC_W];
        cnt <= sat_inc(cnt);
      end
      done_p1 <= tail_v & tail_last;

      unique case (state)
        ACCUM: begin
          if (in_valid && ready_q && in_last) begin
            state   <= DRAIN;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (done_p1) begin
            acc_out   <= acc;
            out_count <= cnt;
            out_ovf   <= ovf;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            ready_q   <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_accumulate_stage.sv
// Three configurations driven in lockstep and checked against a block-sum model.
module tb_mult_accumulate_stage;

  localparam int NI = 3;
  localparam int MLAT[NI] = '{1, 3, 1};
  localparam int ACCW[NI] = '{72, 72, 64};
  localparam int CNTW[NI] = '{8, 8, 2};

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] prod;

  logic [NI-1:0] rdy;
  logic [NI-1:0] ovld;
  logic [NI-1:0] oovf;
  logic [71:0]   acc0, acc1;
  logic [63:0]   acc2;
  logic [7:0]    cnt0, cnt1;
  logic [1:0]    cnt2;
  logic [63:0]   p0, p2;
  logic [63:0]   s1[3];

  int total;
  int fails;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign prod = {32'b0, a} * {32'b0, b};

  // Registered A*B stubs at latency 1 and 3
  always_ff @(posedge clk) begin
    p0    <= prod;
    p2    <= prod;
    s1[0] <= prod;
    s1[1] <= s1[0];
    s1[2] <= s1[1];
  end

  mult_accumulate_stage #(.MUL_LATENCY(1), .ACC_W(72), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[0]),
    .mul_p(p0), .out_valid(ovld[0]), .out_ready(out_ready), .acc_out(acc0),
    .out_count(cnt0), .out_ovf(oovf[0]));

  mult_accumulate_stage #(.MUL_LATENCY(3), .ACC_W(72), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[1]),
    .mul_p(s1[2]), .out_valid(ovld[1]), .out_ready(out_ready), .acc_out(acc1),
    .out_count(cnt1), .out_ovf(oovf[1]));

  mult_accumulate_stage #(.MUL_LATENCY(1), .ACC_W(64), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[2]),
    .mul_p(p2), .out_valid(ovld[2]), .out_ready(out_ready), .acc_out(acc2),
    .out_count(cnt2), .out_ovf(oovf[2]));

  function automatic logic [71:0] acc_of(input int i);
    case (i)
      0:       return acc0;
      1:       return acc1;
      default: return {8'b0, acc2};
    endcase
  endfunction

  function automatic logic [7:0] cnt_of(input int i);
    case (i)
      0:       return cnt0;
      1:       return cnt1;
      default: return {6'b0, cnt2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 20; k++) begin
      if (&rdy) break;
      @(negedge clk);
    end
    check("in_ready_before_block", rdy, {NI{1'b1}});
  endtask

  task automatic drive_pairs(input bit gaps);
    for (int j = 0; j < qa.size(); j++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_last  = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      a        = qa[j];
      b        = qb[j];
      in_valid = 1'b1;
      in_last  = (j == qa.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_block(input bit gaps, input bit hold_check);
    logic [127:0] sum_all;
    logic [127:0] mask;
    logic [71:0]  cap_acc[NI];
    logic [7:0]   cap_cnt[NI];
    logic         cap_ovf[NI];
    bit           got[NI];
    int           lat[NI];
    int           cmax;
    int           n;

    n = qa.size();
    sum_all = '0;
    for (int j = 0; j < n; j++) sum_all += {96'b0, qa[j]} * {96'b0, qb[j]};

    out_ready = hold_check ? 1'b0 : 1'b1;
    wait_ready();
    drive_pairs(gaps);
    for (int i = 0; i < NI; i++) begin
      got[i] = 1'b0;
      lat[i] = 0;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!got[i] && ovld[i]) begin
          got[i]     = 1'b1;
          lat[i]     = k;
          cap_acc[i] = acc_of(i);
          cap_cnt[i] = cnt_of(i);
          cap_ovf[i] = oovf[i];
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      mask = (128'd1 << ACCW[i]) - 128'd1;
      cmax = (1 << CNTW[i]) - 1;
      check($sformatf("out_valid_seen%0d", i), 128'(got[i]), 128'd1);
      check($sformatf("latency%0d", i), 128'(lat[i]), 128'(MLAT[i] + 1));
      check($sformatf("acc_out%0d", i), 128'(cap_acc[i]), sum_all & mask);
      check($sformatf("out_count%0d", i), 128'(cap_cnt[i]), 128'((n > cmax) ? cmax : n));
      check($sformatf("out_ovf%0d", i), 128'(cap_ovf[i]), 128'((sum_all >> ACCW[i]) != 0));
    end
    if (hold_check) begin
      for (int k = 0; k < 10; k++) begin
        check("hold_in_ready", rdy, '0);
        check("hold_out_valid", ovld, {NI{1'b1}});
        check("hold_stable", {acc_of(0), acc_of(1), acc_of(2)},
              {cap_acc[0], cap_acc[1], cap_acc[2]});
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("after_hs_out_valid", ovld, '0);
      check("after_hs_in_ready", rdy, {NI{1'b1}});
    end
  endtask

  task automatic set_pairs_const(input int n, input logic [31:0] x, input logic [31:0] y);
    qa.delete();
    qb.delete();
    for (int j = 0; j < n; j++) begin
      qa.push_back(x);
      qb.push_back(y);
    end
  endtask

  initial begin
    total     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", ovld, '0);
    check("reset_in_ready", rdy, '0);
    check("reset_acc", {acc_of(0), acc_of(1), acc_of(2)}, '0);
    check("reset_count", {cnt_of(0), cnt_of(1), cnt_of(2)}, '0);
    check("reset_ovf", oovf, '0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", rdy, {NI{1'b1}});

    qa = '{32'd2, 32'd4, 32'd6, 32'd8};
    qb = '{32'd3, 32'd5, 32'd7, 32'd9};
    run_block(1'b0, 1'b0);
    check("block4_acc_u0", 128'(acc_of(0)), 128'd140);

    set_pairs_const(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_block(1'b0, 1'b0);

    set_pairs_const(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_block(1'b0, 1'b0);
    check("wrap_acc_u2", 128'(acc2), 128'h FFFF_FFFC_0000_0002);

    qa = '{32'd17, 32'd100};
    qb = '{32'd23, 32'd7};
    run_block(1'b0, 1'b1);
    set_pairs_const(1, 32'd1, 32'd1);
    run_block(1'b0, 1'b0);

    qa = '{32'd2, 32'd4};
    qb = '{32'd3, 32'd5};
    wait_ready();
    drive_pairs(1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_drain_out_valid", ovld, '0);
    check("rst_drain_acc", {acc_of(0), acc_of(1), acc_of(2)}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_drain_ready", rdy, {NI{1'b1}});
    for (int k = 0; k < 6; k++) begin
      if (ovld != '0) check("rst_drain_no_output", ovld, '0);
      @(negedge clk);
    end
    set_pairs_const(1, 32'd3, 32'd3);
    run_block(1'b0, 1'b0);

    set_pairs_const(5, 32'd1, 32'd1);
    run_block(1'b0, 1'b0);

    for (int r = 0; r < 5; r++) begin
      qa.delete();
      qb.delete();
      for (int j = 0; j < $urandom_range(1, 6); j++) begin
        qa.push_back((r == 4) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom);
        qb.push_back((r == 4) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom);
      end
      run_block(1'b1, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
